// File: rtl/seq_det_ctrl.sv
// Sequencer for an 8-bit serial sequence detector. It shifts the search pattern into
// the detector, streams received bits in run mode, and counts hits with an interrupt.
module seq_det_ctrl #(
  parameter int   PAT_W    = 8,
  parameter int   CNT_W    = 8,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [PAT_W-1:0] cfg_pattern,
  output logic             cfg_ready,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  input  logic             clr_cnt,
  output logic             det_load,
  output logic             det_din,
  input  logic             det_dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             match_irq,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;
  localparam int IW = $clog2(PAT_W + 1);

  state_t           state;
  logic [PAT_W-1:0] shadow;
  logic [IW-1:0]    left;
  logic             cfg_acc, bit_acc, hit;

  assign cfg_ready = (state == IDLE) || (state == RUN);
  assign bit_ready = (state == RUN);
  assign busy      = (state == LOAD) || (state == SETTLE);
  assign cfg_acc   = cfg_valid & cfg_ready;
  assign bit_acc   = bit_valid & bit_ready;
  assign hit       = (state == RUN) & det_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      left      <= '0;
      det_load  <= 1'b0;
      det_din   <= IDLE_BIT;
      match_cnt <= '0;
      match_irq <= 1'b0;
    end else begin
      match_irq <= hit;
      if (clr_cnt)
        match_cnt <= '0;
      else if (hit && match_cnt != '1)
        match_cnt <= match_cnt + 1'b1;

      case (state)
        IDLE, RUN: begin
          det_load <= 1'b0;
          det_din  <= bit_acc ? bit_in : IDLE_BIT;
          if (cfg_acc) begin
            state <= LOAD;
            // A bit accepted alongside the new config still owns this slot, so the
            // whole pattern is shifted from the following cycle on.
            if (bit_acc) begin
              shadow <= cfg_pattern;
              left   <= IW'(PAT_W);
            end else begin
              det_load <= 1'b1;
              det_din  <= cfg_pattern[PAT_W-1];
              shadow   <= cfg_pattern << 1;
              left     <= IW'(PAT_W - 1);
            end
          end
        end
        LOAD: begin
          if (left == '0) begin
            state    <= SETTLE;
            det_load <= 1'b0;
            det_din  <= IDLE_BIT;
          end else begin
            det_load <= 1'b1;
            det_din  <= shadow[PAT_W-1];
            shadow   <= shadow << 1;
            left     <= left - 1'b1;
          end
        end
        SETTLE: begin
          state    <= RUN;
          det_load <= 1'b0;
          det_din  <= IDLE_BIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
